// File: rtl/booth_seqmul.sv
// Multi-cycle signed radix-2 Booth multiplier: one add/subtract and shift per clock.
module booth_seqmul #(
   parameter int unsigned WIDTH = 6
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [WIDTH-1:0]     ain,
   input  logic [WIDTH-1:0]     bin,
   output logic                 ready,
   output logic                 done,
   output logic [WIDTH-1:0]     prod,
   output logic [2*WIDTH-1:0]   prod_full,
   output logic                 overflow
);

   localparam int unsigned CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e             state_q, state_d;
   // A and M carry one extra bit so A-M with M at the most negative value cannot wrap.
   logic [WIDTH:0]     a_q, a_d;
   logic [WIDTH:0]     m_q, m_d;
   logic [WIDTH-1:0]   q_q, q_d;
   logic               q1_q, q1_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [2*WIDTH-1:0] pf_q, pf_d;
   logic               ov_q, ov_d;

   logic [WIDTH:0]     sum;
   logic [WIDTH:0]     a_sh;
   logic [WIDTH-1:0]   q_sh;
   logic [2*WIDTH-1:0] full;
   logic [WIDTH:0]     upper;

   // Booth step datapath: conditional add/subtract, then arithmetic shift of {A,Q,q_1}.
   always_comb begin
      sum = a_q;
      unique case ({q_q[0], q1_q})
         2'b01:   sum = a_q + m_q;
         2'b10:   sum = a_q - m_q;
         default: sum = a_q;
      endcase
      a_sh  = {sum[WIDTH], sum[WIDTH:1]};
      q_sh  = {sum[0], q_q[WIDTH-1:1]};
      full  = {a_sh[WIDTH-1:0], q_sh};
      upper = full[2*WIDTH-1:WIDTH-1];
   end

   // Next-state logic: operand capture on handshake, stepping in RUN, result capture on last step.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      m_d     = m_q;
      q_d     = q_q;
      q1_d    = q1_q;
      cnt_d   = cnt_q;
      pf_d    = pf_q;
      ov_d    = ov_q;
      unique case (state_q)
         StIdle, StDone: begin
            if (start) begin
               m_d     = {ain[WIDTH-1], ain};
               q_d     = bin;
               a_d     = '0;
               q1_d    = 1'b0;
               cnt_d   = CW'(WIDTH);
               state_d = StRun;
            end else begin
               state_d = StIdle;
            end
         end
         StRun: begin
            a_d   = a_sh;
            q_d   = q_sh;
            q1_d  = q_q[0];
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               state_d = StDone;
               pf_d    = full;
               // Overflow when the upper bits are not a pure sign extension of bit WIDTH-1.
               ov_d    = ~((&upper) | ~(|upper));
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         a_q     <= '0;
         m_q     <= '0;
         q_q     <= '0;
         q1_q    <= 1'b0;
         cnt_q   <= '0;
         pf_q    <= '0;
         ov_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         m_q     <= m_d;
         q_q     <= q_d;
         q1_q    <= q1_d;
         cnt_q   <= cnt_d;
         pf_q    <= pf_d;
         ov_q    <= ov_d;
      end
   end

   assign ready     = (state_q != StRun);
   assign done      = (state_q == StDone);
   assign prod_full = pf_q;
   assign prod      = pf_q[WIDTH-1:0];
   assign overflow  = ov_q;

endmodule

// File: tb/tb_booth_seqmul.sv
// Self-checking bench for booth_seqmul: directed cases plus random operands vs. integer model.
module tb_booth_seqmul;

   logic        clk = 1'b0;
   logic        rst;
   logic        start6, ready6, done6, ovf6;
   logic [5:0]  ain6, bin6, prod6;
   logic [11:0] pf6;
   logic        start8, ready8, done8, ovf8;
   logic [7:0]  ain8, bin8, prod8;
   logic [15:0] pf8;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   booth_seqmul #(.WIDTH(6)) dut6 (
      .clk(clk), .rst(rst), .start(start6), .ain(ain6), .bin(bin6), .ready(ready6),
      .done(done6), .prod(prod6), .prod_full(pf6), .overflow(ovf6)
   );

   booth_seqmul #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .ain(ain8), .bin(bin8), .ready(ready8),
      .done(done8), .prod(prod8), .prod_full(pf8), .overflow(ovf8)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: exact integer product and its representability in w signed bits.
   function automatic logic ref_ovf(input int p, input int w);
      return (p < -(1 <<< (w - 1))) || (p > ((1 <<< (w - 1)) - 1));
   endfunction

   task automatic mul6(input int a, input int b);
      int          p;
      int          lat;
      logic [11:0] e;
      p   = a * b;
      e   = p[11:0];
      lat = 99;
      for (int k = 0; k < 20 && !ready6; k++) tick();
      check("ready6_before_start", 64'(ready6), 64'(1));
      ain6   = a[5:0];
      bin6   = b[5:0];
      start6 = 1'b1;
      tick();
      start6 = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         tick();
         ain6 = 6'($urandom);
         bin6 = 6'($urandom);
         if (done6) begin
            lat = k;
            break;
         end
      end
      check("lat6", 64'(lat), 64'(6));
      check("prod_full6", 64'(pf6), 64'(e));
      check("prod6", 64'(prod6), 64'(e[5:0]));
      check("ovf6", 64'(ovf6), 64'(ref_ovf(p, 6)));
      tick();
      check("hold6", 64'(pf6), 64'(e));
      check("done6_pulse", 64'(done6), 64'(0));
   endtask

   task automatic mul8(input int a, input int b);
      int          p;
      int          lat;
      logic [15:0] e;
      p   = a * b;
      e   = p[15:0];
      lat = 99;
      ain8   = a[7:0];
      bin8   = b[7:0];
      start8 = 1'b1;
      tick();
      start8 = 1'b0;
      for (int k = 1; k <= 24; k++) begin
         tick();
         if (done8) begin
            lat = k;
            break;
         end
      end
      check("lat8", 64'(lat), 64'(8));
      check("prod_full8", 64'(pf8), 64'(e));
      check("prod8", 64'(prod8), 64'(e[7:0]));
      check("ovf8", 64'(ovf8), 64'(ref_ovf(p, 8)));
      tick();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          ndone;
      int          t1;
      int          t2;
      logic [11:0] got;
      rst    = 1'b1;
      start6 = 1'b0;
      start8 = 1'b0;
      ain6   = '0;
      bin6   = '0;
      ain8   = '0;
      bin8   = '0;
      tick();
      tick();
      rst = 1'b0;
      tick();
      check("rst_ready", 64'(ready6), 64'(1));
      check("rst_done", 64'(done6), 64'(0));
      check("rst_prod_full", 64'(pf6), 64'(0));
      check("rst_prod", 64'(prod6), 64'(0));
      check("rst_ovf", 64'(ovf6), 64'(0));
      ndone = 0;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (done6) ndone++;
      end
      check("idle_no_done", 64'(ndone), 64'(0));

      // Directed operand cases.
      mul6(3, -5);
      mul6(7, 9);
      mul6(-32, -32);
      mul6(0, -32);
      mul6(-32, 31);
      mul6(31, 31);

      // start during RUN must be ignored.
      ain6 = 6'd5; bin6 = 6'd6; start6 = 1'b1;
      tick();
      start6 = 1'b0;
      ndone  = 0;
      got    = '0;
      for (int k = 1; k <= 20; k++) begin
         tick();
         if (done6) begin
            ndone++;
            if (ndone == 1) got = pf6;
         end
         if (k == 2) begin
            start6 = 1'b1; ain6 = '1; bin6 = '1;
         end else begin
            start6 = 1'b0; ain6 = ~ain6; bin6 = ~bin6;
         end
      end
      check("run_start_ndone", 64'(ndone), 64'(1));
      check("run_start_prod", 64'(got), 64'(30));
      check("run_start_ovf", 64'(ovf6), 64'(0));

      // Reset in the third RUN cycle aborts.
      ain6 = 6'd4; bin6 = 6'd4; start6 = 1'b1;
      tick();
      start6 = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("abort_ready", 64'(ready6), 64'(1));
      check("abort_done", 64'(done6), 64'(0));
      check("abort_prod_full", 64'(pf6), 64'(0));
      check("abort_ovf", 64'(ovf6), 64'(0));
      ndone = 0;
      for (int k = 0; k < 10; k++) begin
         tick();
         if (done6) ndone++;
      end
      check("abort_no_done", 64'(ndone), 64'(0));
      mul6(-2, 3);

      // Back-to-back via start held high through DONE.
      ain6 = 6'h3D; bin6 = 6'd2; start6 = 1'b1;
      tick();
      ndone = 0; t1 = 0; t2 = 0;
      for (int k = 1; k <= 30 && ndone < 2; k++) begin
         tick();
         if (done6) begin
            ndone++;
            if (ndone == 1) begin
               t1 = k;
               check("b2b_first", 64'(pf6), 64'(12'hFFA));
               ain6 = 6'd2; bin6 = 6'd2;
            end else begin
               t2 = k;
               check("b2b_second", 64'(pf6), 64'(12'h004));
               start6 = 1'b0;
            end
         end
      end
      start6 = 1'b0;
      check("b2b_first_lat", 64'(t1), 64'(6));
      check("b2b_gap", 64'(t2 - t1), 64'(7));
      tick();

      // Random operands with random idle gaps.
      for (int i = 0; i < 40; i++) begin
         int gap;
         gap = int'($urandom_range(0, 3));
         for (int g = 0; g < gap; g++) tick();
         mul6(int'($urandom_range(0, 63)) - 32, int'($urandom_range(0, 63)) - 32);
      end

      // WIDTH=8 instance.
      mul8(-128, 127);
      mul8(-128, -128);
      for (int i = 0; i < 10; i++)
         mul8(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
